// File: rtl/add_sub_lopd_norm_pipe_if.sv
// add_sub_lopd_norm_pipe_if
//   Handshake/data bundle for the leading-one normaliser.
//   slave  : the normaliser side (takes input beats, produces results).
//   master : the upstream/downstream side (adder in front, exponent adjust behind).
//   Signals:
//     i_valid/o_ready/i_data/i_tag              input beat
//     o_valid/i_ready/o_data/o_lzc/o_zero_flag/o_tag   result beat
interface add_sub_lopd_norm_pipe_if #(
  parameter int DATA_W = 24,
  parameter int TAG_W  = 9
);
  localparam int LZC_W = $clog2(DATA_W + 1);

  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic [TAG_W-1:0]  i_tag;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [LZC_W-1:0]  o_lzc;
  logic              o_zero_flag;
  logic [TAG_W-1:0]  o_tag;

  modport slave (
    input  i_valid, i_data, i_tag, i_ready,
    output o_ready, o_valid, o_data, o_lzc, o_zero_flag, o_tag
  );

  modport master (
    output i_valid, i_data, i_tag, i_ready,
    input  o_ready, o_valid, o_data, o_lzc, o_zero_flag, o_tag
  );
endinterface

// File: rtl/add_sub_lopd_norm_pipe.sv
// add_sub_lopd_norm_pipe
//   Two-stage leading-one detect + left-normalise for the add/sub mantissa path.
//   Stage 1 registers the magnitude, its tag and its leading-zero count.
//   Stage 2 applies the shift (log barrel shifter) and drives the result.
//   Ports:
//     i_clk    rising-edge clock
//     i_rst_n  async active-low reset (release is expected synchronous to i_clk)
//     i_flush  sync flush, drops everything in flight and refuses input that cycle
//     bus      slave side of add_sub_lopd_norm_pipe_if (valid/ready in and out)
module add_sub_lopd_norm_pipe #(
  parameter int DATA_W = 24,
  parameter int TAG_W  = 9
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  add_sub_lopd_norm_pipe_if.slave    bus
);
  localparam int LZC_W = $clog2(DATA_W + 1);

  logic              s1_vld_q, s2_vld_q;
  logic [DATA_W-1:0] s1_data_q, s2_data_q;
  logic [LZC_W-1:0]  s1_lzc_q, s2_lzc_q;
  logic              s1_zero_q, s2_zero_q;
  logic [TAG_W-1:0]  s1_tag_q, s2_tag_q;

  logic              en1, en2, in_hs;
  logic [LZC_W-1:0]  lzc_d;
  logic              zero_d;
  logic [DATA_W-1:0] norm_d;

  // A stage may take new data when it is empty or the stage after it is moving.
  assign en2       = ~s2_vld_q | bus.i_ready;
  assign en1       = ~s1_vld_q | en2;
  assign bus.o_ready = en1 & ~i_flush;
  assign in_hs     = bus.i_valid & bus.o_ready;

  // Priority encoder: scanning upward, the highest set bit gets the last word.
  always_comb begin
    lzc_d = LZC_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (bus.i_data[i]) lzc_d = LZC_W'(DATA_W - 1 - i);
    end
  end
  assign zero_d = ~|bus.i_data;

  // Log shifter: stage k shifts by 2^k when lzc bit k is set.
  logic [LZC_W:0][DATA_W-1:0] sh;
  assign sh[0] = s1_data_q;
  for (genvar k = 0; k < LZC_W; k++) begin : g_shift
    assign sh[k+1] = s1_lzc_q[k] ? (sh[k] << (2**k)) : sh[k];
  end
  assign norm_d = s1_zero_q ? '0 : sh[LZC_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_lzc_q  <= '0;
      s1_zero_q <= 1'b0;
      s1_tag_q  <= '0;
      s2_data_q <= '0;
      s2_lzc_q  <= '0;
      s2_zero_q <= 1'b0;
      s2_tag_q  <= '0;
    end else begin
      if (i_flush) begin
        s1_vld_q <= 1'b0;
        s2_vld_q <= 1'b0;
      end else begin
        if (en2) s2_vld_q <= s1_vld_q;
        // o_ready equals en1 outside flush, so this is exactly the input handshake.
        if (en1) s1_vld_q <= bus.i_valid;
      end
      // Payload only moves with a live beat; idle stages keep their old bits.
      if (in_hs) begin
        s1_data_q <= bus.i_data;
        s1_lzc_q  <= lzc_d;
        s1_zero_q <= zero_d;
        s1_tag_q  <= bus.i_tag;
      end
      if (en2 && s1_vld_q && !i_flush) begin
        s2_data_q <= norm_d;
        s2_lzc_q  <= s1_lzc_q;
        s2_zero_q <= s1_zero_q;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  assign bus.o_valid     = s2_vld_q;
  assign bus.o_data      = s2_data_q;
  assign bus.o_lzc       = s2_lzc_q;
  assign bus.o_zero_flag = s2_zero_q;
  assign bus.o_tag       = s2_tag_q;
endmodule

// File: doc/add_sub_lopd_norm_pipe.md
Name: add_sub_lopd_norm_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational leading-one position detector in the FPU add/sub path.
- Finds the leading one of a DATA_W-bit magnitude, left-normalises it, and reports the shift count and a zero flag.
- Carries an aligned sideband tag (sign/exponent) through the pipeline.
- Sits between the add/sub mantissa adder and the exponent-adjust/rounding stage, with valid/ready backpressure.

Parameters:
- DATA_W, 24, magnitude width in bits; legal range 2..64.
- TAG_W, 9, sideband width passed through unchanged (sign + exponent).
- LZC_W, $clog2(DATA_W+1), derived, not overridden; width of the shift-count output.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush; kills all in-flight entries.
- i_valid  in  1  input data valid.
- o_ready  out  1  block accepts input this cycle.
- i_data  in  DATA_W  unsigned magnitude to normalise.
- i_tag  in  TAG_W  sideband, returned with its result.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_data  out  DATA_W  normalised magnitude; MSB set unless zero.
- o_lzc  out  LZC_W  leading-zero count = left-shift amount applied.
- o_zero_flag  out  1  input was all zeros.
- o_tag  out  TAG_W  sideband of this result.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, o_valid=0, o_data=0, o_lzc=0, o_zero_flag=0, o_tag=0.
- Stage 1 register, loaded on input handshake: data, tag, and lzc = number of zeros above the highest set bit.
  - i_data[DATA_W-1]=1 gives lzc=0; only bit 0 set gives lzc=DATA_W-1.
  - All zeros gives lzc=DATA_W and zero=1.
- Stage 2 register (outputs):
  - o_data = s1_data << s1_lzc, truncated to DATA_W bits; o_data=0 when zero=1.
  - o_lzc = s1_lzc; o_zero_flag = s1_zero; o_tag = s1_tag.
- Latency: 2 cycles, input handshake to o_valid, when not stalled. Throughput: 1 result per cycle.
- Handshake enables:
  - en2 = ~o_valid | i_ready
  - en1 = ~s1_valid | en2
  - o_ready = en1, combinational from i_ready and the valid flags; there is no skid buffer.
- Register updates:
  - Input handshake (i_valid & o_ready) loads stage 1.
  - en2 moves s1 into s2; s2_valid takes s1_valid.
  - If en1 is high but there is no input handshake, s1_valid clears.
- Stall (o_valid=1, i_ready=0):
  - o_data, o_lzc, o_zero_flag and o_tag hold stable.
  - o_valid stays 1 until accepted.
  - With both stages full, o_ready=0.
- Simultaneous accept and new input: a full pipe with i_ready=1 and i_valid=1 shifts every stage in one cycle, with no bubble.
- Flush: i_flush=1 clears s1_valid and o_valid on the next edge.
  - Any input offered in the same cycle is dropped.
  - o_ready is forced to 0 during flush.
  - Data registers need not clear.
- Reset mid-operation: all valids drop immediately (async); results in flight are lost and nothing reappears after release.
- Data registers load only on their enable, which reduces toggling; the contents of invalid stages are don't-care.
- Arithmetic:
  - The LZC is a priority encoder built generically (loop or tree) for any DATA_W.
  - The shifter is a logarithmic barrel shifter with LZC_W stages; all operations are unsigned.

Test Plan:
- DATA_W=8, i_data=8'h80 -> two cycles later o_data=8'h80, o_lzc=0, o_zero_flag=0.
- DATA_W=8, sequence 8'h01, 8'h13, 8'h00 on consecutive cycles with i_ready=1 -> results on consecutive cycles:
  - (8'h80, lzc=7, zero=0)
  - (8'h98, lzc=3, zero=0)
  - (8'h00, lzc=8, zero=1)
- DATA_W=24, i_data=24'h000ABC, i_tag=9'h17F -> o_data=24'hABC000, o_lzc=12, o_tag=9'h17F.
- Backpressure: i_ready=0 for 4 cycles while streaming values 1..4 -> o_ready falls to 0 once both stages are full. After i_ready returns, results appear in order with no loss or duplication, and outputs stay stable while stalled.
- Flush with two entries in flight -> o_valid=0 the following cycle; the next accepted input produces the only subsequent result.
- Assert i_rst_n=0 asynchronously mid-stream -> o_valid=0 and all outputs=0 without waiting for a clock edge; no stale result after release.
